// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 encodings and helpers for the burst read master.
//   BURST_INCR        ARBURST encoding for incrementing bursts
//   RESP_*            RRESP encodings
//   axi_rresp_t       RRESP field type
//   rd_state_t        read-master FSM state (also exported for debug)
//   size_of()         ARSIZE value for a given data bus width in bits
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [1:0] axi_rresp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_t;

    // ARSIZE is log2 of the number of bytes per beat.
    function automatic logic [2:0] size_of(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_read_master_if.sv
// ---------------------------------------------------------------------------
// axi_burst_read_master_if
// AXI4 read address (AR) and read data (R) channels.
//   master modport : drives AR*, RREADY; samples ARREADY, R*
//   slave modport  : mirror image
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where VALID and READY are both high. A source that raises VALID keeps
// VALID and its payload stable until that transfer; READY may change freely
// and may depend combinationally on VALID.
// ---------------------------------------------------------------------------
interface axi_burst_read_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [2:0]        ARPROT;
    logic [ID_W-1:0]   ARID;

    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic [ID_W-1:0]   RID;

    modport master (
        output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARID,
        input  ARREADY,
        input  RVALID, RDATA, RRESP, RLAST, RID,
        output RREADY
    );

    modport slave (
        input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARID,
        output ARREADY,
        output RVALID, RDATA, RRESP, RLAST, RID,
        input  RREADY
    );
endinterface

// File: rtl/rsp_pipe_reg.sv
// ---------------------------------------------------------------------------
// rsp_pipe_reg
// One-entry valid/ready register carrying data plus last/err flags.
//   clk, rst_n            clock, asynchronous active-low reset
//   i_valid/o_ready       upstream handshake
//   i_data/i_last/i_err   upstream payload
//   o_valid/i_ready       downstream handshake
//   o_data/o_last/o_err   registered payload, stable while stalled
// Upstream must only present i_valid when it intends the load to happen in
// the same cycle as o_ready; the register accepts a new entry when empty or
// when the current one is leaving, giving one transfer per cycle.
// ---------------------------------------------------------------------------
module rsp_pipe_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    input  logic         i_err,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_last,
    output logic         o_err
);
    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_last;
    logic         r_err;

    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
            r_err   <= i_err;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_err   = r_err;
endmodule

// File: rtl/axi_burst_read_master.sv
// ---------------------------------------------------------------------------
// axi_burst_read_master
// Turns one client read request into a single AXI4 INCR burst of
// 1..MAX_BEATS beats and returns the beats through a registered
// valid/ready stage with full backpressure. One burst outstanding.
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   req_valid/req_ready    client request handshake
//   req_addr, req_len      start address, beats minus one
//   rsp_valid/rsp_ready    client beat handshake
//   rsp_data/last/err      beat payload; err only on the last beat
//   axi (master modport)   AXI4 AR and R channels
//   o_dbg_state            current FSM state
// ---------------------------------------------------------------------------
module axi_burst_read_master
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int AXI_ID    = 0,
    parameter int MAX_BEATS = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [$clog2(MAX_BEATS)-1:0] req_len,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_last,
    output logic                         rsp_err,
    axi_burst_read_master_if.master      axi,
    output rd_state_t                    o_dbg_state
);
    localparam int LEN_W = $clog2(MAX_BEATS);
    // One extra bit so a count past len (missing RLAST) is representable.
    localparam int CNT_W = LEN_W + 1;
    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BYTES - 1);

    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic             r_arvalid;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic             w_pipe_ready;
    logic             w_rbeat;
    logic             w_at_len;
    logic             w_beat_err;
    logic             w_err_total;

    // R channel -------------------------------------------------------------
    assign axi.RREADY  = (r_state == ST_DATA) && w_pipe_ready;
    assign w_rbeat     = axi.RVALID && axi.RREADY;
    assign w_at_len    = (r_cnt == {1'b0, r_len});
    assign w_beat_err  = (axi.RRESP != RESP_OKAY)
                       || (axi.RID != ID_W'(AXI_ID))
                       || (axi.RLAST && !w_at_len)
                       || (w_at_len && !axi.RLAST);
    assign w_err_total = r_err || w_beat_err;

    // FSM next state / request ready -------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (axi.ARREADY) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                // The RLAST beat ends the burst regardless of the count.
                if (w_rbeat && axi.RLAST) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (rsp_valid && rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= ST_IDLE;
            r_arvalid <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arvalid <= (w_state_nxt == ST_ADDR);
            if (r_state == ST_IDLE && req_valid) begin
                r_addr <= req_addr;
                r_len  <= req_len;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end
            if (w_rbeat) begin
                r_err <= w_err_total;
                // Saturate so a runaway burst cannot wrap back onto len.
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // AR channel ------------------------------------------------------------
    assign axi.ARVALID = r_arvalid;
    assign axi.ARADDR  = r_addr & ADDR_MASK;
    assign axi.ARLEN   = 8'(r_len);
    assign axi.ARSIZE  = size_of(DATA_W);
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARPROT  = 3'b000;
    assign axi.ARID    = ID_W'(AXI_ID);

    // Output stage: err is only meaningful on the RLAST beat.
    rsp_pipe_reg #(.W(DATA_W)) u_rsp_pipe (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .i_valid (w_rbeat),
        .o_ready (w_pipe_ready),
        .i_data  (axi.RDATA),
        .i_last  (axi.RLAST),
        .i_err   (axi.RLAST && w_err_total),
        .o_valid (rsp_valid),
        .i_ready (rsp_ready),
        .o_data  (rsp_data),
        .o_last  (rsp_last),
        .o_err   (rsp_err)
    );

    assign o_dbg_state = r_state;

`ifndef SYNTHESIS
    // Bursts must stay inside one 4 KB page; that is the client's job.
    logic [31:0] w_4k_end;
    assign w_4k_end = {20'b0, req_addr[11:0] & ~12'(BYTES - 1)}
                    + (32'(req_len) + 32'd1) * 32'(BYTES);
    always @(posedge ACLK) begin
        if (ARESETn && r_state == ST_IDLE && req_valid) begin
            assert (w_4k_end <= 32'd4096)
                else $error("axi_burst_read_master: burst crosses a 4 KB boundary");
        end
    end
`endif
endmodule

// File: doc/axi_burst_read_master.md
Name: axi_burst_read_master

Overview:
- Parametrised AXI4 read master that turns a single client read request into one INCR burst of 1..MAX_BEATS beats.
- Returns the data to the client beat by beat through a registered valid/ready output stage, with full backpressure.
- Sits between the LSU/IFU fetch logic and the memory-side AXI interconnect, as the burst-capable successor of the single-beat memory read path.
- Pure synthesizable RTL.

Parameters:
- ADDR_W, 32, address width of req_addr and ARADDR
- DATA_W, 64, data bus width; power of two, 32..512
- ID_W, 4, AXI ID width
- AXI_ID, 0, constant ID driven on ARID; RID is checked against it
- MAX_BEATS, 8, maximum beats per burst; power of two, ≤256

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- req_valid  in  1  client request valid
- req_ready  out  1  master can accept a request
- req_addr  in  ADDR_W  start address
- req_len  in  $clog2(MAX_BEATS)  number of beats minus 1
- rsp_valid  out  1  output beat valid
- rsp_ready  in  1  client accepts beat
- rsp_data  out  DATA_W  beat data
- rsp_last  out  1  final beat of the burst
- rsp_err  out  1  on the last beat: the burst saw an error
- ARVALID/ARREADY  out/in  1  read address handshake
- ARADDR  out  ADDR_W
- ARLEN  out  8
- ARSIZE  out  3
- ARBURST  out  2
- ARPROT  out  3
- ARID  out  ID_W
- RVALID/RREADY  in/out  1  read data handshake
- RDATA  in  DATA_W
- RRESP  in  2
- RLAST  in  1
- RID  in  ID_W

Behaviour:
- Reset (async assert, sync release): state=IDLE; ARVALID=0; RREADY=0; rsp_valid=0; rsp_last=0; rsp_err=0; req_ready=1; beat counter=0; sticky error=0; address/len registers=0.
- Constant AR fields:
  - ARBURST=2'b01 (INCR), ARSIZE=log2(DATA_W/8), ARPROT=3'b000, ARID=AXI_ID.
  - ARADDR=latched address with the low log2(DATA_W/8) bits forced to 0.
  - ARLEN=zero-extended latched req_len.
- FSM states: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr/len, clear counter and sticky error, go to ADDR.
- ADDR:
  - ARVALID=1; registered, asserted the cycle after acceptance.
  - Address and len are held stable until ARREADY.
  - ARVALID never deasserts without a handshake.
  - On ARVALID&&ARREADY: go to DATA.
  - Request-to-ARVALID latency is 1 cycle.
- DATA:
  - RREADY = !rsp_valid || rsp_ready (one-entry pipeline register).
  - On RVALID&&RREADY: load rsp_data=RDATA, rsp_valid=1, increment the counter.
  - Error conditions, OR'd into the sticky error:
    - RRESP != OKAY;
    - RID != AXI_ID;
    - RLAST asserted while counter != len;
    - counter == len without RLAST.
  - The burst terminates on the beat carrying RLAST, whatever the counter says. rsp_last=1 on that beat; rsp_err=sticky error including that beat.
  - If counter==len and RLAST is absent, beats keep being accepted and forwarded with rsp_last=0 until RLAST arrives, so the bus cannot hang.
  - After the RLAST beat is captured: RREADY=0, go to DRAIN.
- DRAIN:
  - Wait for rsp_valid&&rsp_ready on the last beat, then go to IDLE.
  - req_ready rises the following cycle; no request overlap, one burst outstanding.
- Output register:
  - rsp_* hold stable while rsp_valid&&!rsp_ready.
  - With rsp_ready held high, throughput is 1 beat/cycle.
  - rsp_err is 0 on non-last beats.
- Boundary conditions:
  - req_len=0 gives a single beat; RLAST is expected on beat 0.
  - Counter width is $clog2(MAX_BEATS)+1 so it cannot overflow at len=MAX_BEATS-1.
  - A burst crossing a 4 KB boundary is the client's responsibility; a simulation-only assertion flags it.
- Reset mid-burst: asynchronous return to IDLE with all outputs at reset values; any beats in flight are dropped.

Decomposition:
- Package axi_pkg holds:
  - BURST_INCR=2'b01;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - typedef axi_rresp_t;
  - function size_of(DATA_W) returning ARSIZE.
- One sub-module, rsp_pipe_reg: a one-entry valid/ready register with data/last/err payload, parametrised by width. The FSM stays in axi_burst_read_master.

Test Plan:
- Single beat: req addr=0x80000008, len=0; slave ARREADY immediately, RDATA=0xDEADBEEF_00000001, RLAST=1 → ARADDR=0x80000008, ARLEN=0, ARSIZE=3; one rsp beat with rsp_last=1, rsp_err=0; req_ready returns after the handshake.
- 8-beat burst: len=7, RDATA=i, rsp_ready=1 → ARLEN=7; 8 consecutive rsp beats with data 0..7, rsp_last only on beat 7, no bubbles.
- Backpressure: len=3, rsp_ready toggles 1,0,0,1… → RREADY low whenever rsp_valid&&!rsp_ready; data order 0..3 preserved; no beat lost or duplicated.
- AR stall: ARREADY low for 5 cycles → ARVALID and ARADDR stable for all 5 cycles; DATA state entered only after the handshake.
- Errors:
  - len=3, RRESP=SLVERR on beat 1 → rsp_err=1 only on beat 3.
  - Separate run: RLAST on beat 1 of len=3 → burst ends after 2 beats with rsp_last=1, rsp_err=1.
- Reset mid-burst: ARESETn low for 1 cycle during beat 2 of 8 → outputs at reset values immediately; next request completes cleanly.
